// File: rtl/keypad_matrix_emu_pkg.sv
// Shared keypad definitions: sequencer states, key code layout and matrix width.
package keypad_matrix_emu_pkg;

    localparam int KP_LINES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } kp_state_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_code_t;

    function automatic logic [1:0] key_row(input key_code_t k);
        return k.row;
    endfunction

    function automatic logic [1:0] key_col(input key_code_t k);
        return k.col;
    endfunction

endpackage

// File: rtl/keypad_matrix_emu_phase_counter.sv
// Phase counter: clears on load, counts enabled cycles, flags the last cycle of a phase.
module keypad_phase_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/keypad_matrix_emu.sv
// Keypad matrix emulator: accepts a key code, then plays a bounced press/hold/release
// on the column returns for whichever row strobe selects that key.
module keypad_matrix_emu
    import keypad_matrix_emu_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int GAP_CYCLES    = 8,
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic                key_ready,
    input  logic [KP_LINES-1:0] row,
    output logic [KP_LINES-1:0] col,
    output logic                busy,
    output logic                done,
    output kp_state_e           o_dbg_state
);

    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);

    generate
        if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
            $error("keypad_matrix_emu: HOLD_CYCLES and GAP_CYCLES must be >= 1");
        end
    endgenerate

    kp_state_e        r_state;
    kp_state_e        w_next;
    key_code_t        r_key;
    logic             r_done;
    logic             w_xfer;
    logic             w_load;
    logic             w_cnt_en;
    logic             w_tc;
    logic             w_done_next;
    logic             w_contact;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_last;

    // The counter only advances inside a phase; IDLE keeps it parked at zero.
    assign w_cnt_en = en && (r_state != ST_IDLE);

    keypad_phase_counter #(.W(CNT_W)) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_en    (w_cnt_en),
        .i_last  (w_last),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    assign key_ready = (r_state == ST_IDLE) && en && !rst;
    assign w_xfer    = key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_next;
            if (w_xfer) begin
                r_key <= key_code_t'(key_code);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_done_next = 1'b0;
        w_last      = '0;
        w_contact   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_next = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
                    w_load = 1'b1;
                end
            end
            ST_BOUNCE_IN: begin
                w_last    = BOUNCE_LAST;
                w_contact = w_count[0];
                if (en && w_tc) begin
                    w_next = ST_HOLD;
                    w_load = 1'b1;
                end
            end
            ST_HOLD: begin
                w_last    = HOLD_LAST;
                w_contact = 1'b1;
                if (en && w_tc) begin
                    w_next = HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
                    w_load = 1'b1;
                end
            end
            ST_BOUNCE_OUT: begin
                w_last    = BOUNCE_LAST;
                w_contact = ~w_count[0];
                if (en && w_tc) begin
                    w_next = ST_GAP;
                    w_load = 1'b1;
                end
            end
            ST_GAP: begin
                w_last = GAP_LAST;
                if (en && w_tc) begin
                    w_next      = ST_IDLE;
                    w_load      = 1'b1;
                    w_done_next = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
                w_load = 1'b1;
            end
        endcase
    end

    // Column return is purely combinational from the row strobes.
    always_comb begin
        col = '0;
        if (w_contact && row[key_row(r_key)]) begin
            col = KP_LINES'(1) << key_col(r_key);
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Bench for keypad_matrix_emu: directed scenarios then random traffic, all checked
// against a timeline model counting enabled cycles since each accepted key.
module tb_keypad_matrix_emu;
    import keypad_matrix_emu_pkg::*;

    localparam int B = 4;
    localparam int H = 16;
    localparam int G = 8;
    localparam int T = 2 * B + H + G;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] row;
    logic [3:0] col;
    logic       busy;
    logic       done;
    kp_state_e  dbg_state;

    always #5 clk = ~clk;

    keypad_matrix_emu #(
        .HOLD_CYCLES   (H),
        .GAP_CYCLES    (G),
        .BOUNCE_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .row         (row),
        .col         (col),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a press is a timeline of T enabled cycles measured from the accepting edge.
    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic [3:0] m_key    = 4'h0;
    bit         m_done   = 1'b0;

    function automatic bit m_contact();
        if (!m_active)                return 1'b0;
        if (m_k < B)                  return (m_k % 2) == 1;
        if (m_k < B + H)              return 1'b1;
        if (m_k < 2 * B + H)          return ((m_k - B - H) % 2) == 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_col(input logic [3:0] r);
        int kr;
        int kc;
        logic [3:0] res;
        kr  = m_key / 4;
        kc  = m_key % 4;
        res = 4'b0000;
        if (m_contact() && r[kr]) res[kc] = 1'b1;
        return res;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_key    = 4'h0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                if (en) begin
                    m_k++;
                    if (m_k == T) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (en && key_valid) begin
                m_active = 1'b1;
                m_k      = 0;
                m_key    = key_code;
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("col", col, m_col(row));
        check("key_ready", {3'b000, key_ready}, {3'b000, !m_active && en && !rst});
        check("busy", {3'b000, busy}, {3'b000, m_active});
        check("done", {3'b000, done}, {3'b000, m_done});
    endtask

    task automatic wait_done(input string tag, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        check_int({tag, "_seen"}, int'(seen), 1);
    endtask

    initial begin
        int n;
        int closed;
        int run;
        int max_run;
        int n_done;

        rst       = 1'b1;
        en        = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h5;
        row       = 4'b1111;

        // Reset held with a key on offer
        step();
        step();
        check("rst_col", col, 4'b0000);
        rst       = 1'b0;
        key_valid = 1'b0;
        step();

        // Walked rows, key 0110
        key_code  = 4'b0110;
        row       = 4'b0001;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            row = {row[2:0], row[3]};
            step();
            n++;
            if (done === 1'b1) break;
        end
        check_int("done_latency", n, B + H + B + G);

        // Fixed row 0001, key 0011: count closed cycles and longest closed run
        key_code  = 4'b0011;
        row       = 4'b0001;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        closed = 0; run = 0; max_run = 0;
        for (int i = 0; i < T; i++) begin
            step();
            if (col === 4'b1000) begin
                closed++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check_int("closed_cycles", closed, 2 + H + 2);
        check_int("longest_closed_run", max_run, 1 + H + 1);

        // Enable dropped for 5 cycles in HOLD cycle 3
        key_code  = 4'b1001;
        row       = 4'b0100;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (B + 2) step();
        en = 1'b0;
        repeat (5) begin
            step();
            check("freeze_col", col, 4'b0010);
        end
        en = 1'b1;
        wait_done("freeze", n);
        check_int("freeze_total", n + B + 2 + 5, T + 5);

        // Second offer while busy is ignored until done
        key_code  = 4'b1111;
        row       = 4'b1000;
        key_valid = 1'b1;
        step();
        key_code = 4'b0100;
        row      = 4'b0010;
        wait_done("busy_offer", n);
        check_int("busy_offer_latency", n, T);
        check("ready_at_done", {3'b000, key_ready}, 4'b0001);
        step();
        check("busy_after_accept", {3'b000, busy}, 4'b0001);
        key_valid = 1'b0;
        wait_done("second_key", n);

        // Reset in HOLD cycle 3 aborts with no done
        key_code  = 4'b1110;
        row       = 4'b1000;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (B + 2) step();
        check("hold_col_before_rst", col, 4'b0100);
        rst = 1'b1;
        step();
        check("abort_col", col, 4'b0000);
        check("abort_busy", {3'b000, busy}, 4'b0000);
        rst = 1'b0;
        n_done = 0;
        repeat (T + 8) begin
            step();
            if (done === 1'b1) n_done++;
        end
        check_int("abort_no_done", n_done, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            en        = ($urandom_range(0, 7) != 0);
            key_valid = ($urandom_range(0, 3) == 0);
            key_code  = 4'($urandom_range(0, 15));
            row       = 4'($urandom_range(0, 15));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_emu.md
KEYPAD_MATRIX_EMU -- requirements
Module: keypad_matrix_emu

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, number of clk cycles the key contact stays closed after bounce-in.
REQ-002 Parameter GAP_CYCLES, default 8, number of clk cycles the contact stays open after release before the next key is accepted.
REQ-003 Parameter BOUNCE_CYCLES, default 4, length of each bounce window (press and release); 0 disables bouncing.
REQ-004 Port clk  input  1  system clock; sole clock.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port en  input  1  sequencer enable; when low, the state machine and counters hold their values.
REQ-007 Port key_valid  input  1  a key code is offered.
REQ-008 Port key_code  input  4  key to press: row index [3:2], column index [1:0].
REQ-009 Port key_ready  output  1  the block accepts key_code this cycle.
REQ-010 Port row  input  4  scanner row strobes, active-high, normally one-hot.
REQ-011 Port col  output  4  matrix column returns, active-high.
REQ-012 Port busy  output  1  a key sequence is in progress (any state other than IDLE).
REQ-013 Port done  output  1  one-cycle pulse on the GAP-to-IDLE transition.

Function
REQ-014 States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
REQ-015 key_ready = (state==IDLE) && en; a transfer occurs when key_valid && key_ready, capturing key_code into an internal register.
REQ-016 On transfer: next state is BOUNCE_IN if BOUNCE_CYCLES>0, else HOLD; the phase counter loads 0.
REQ-017 BOUNCE_IN lasts exactly BOUNCE_CYCLES enabled cycles; contact = counter bit 0 (closed on odd counts); then HOLD.
REQ-018 HOLD lasts exactly HOLD_CYCLES enabled cycles with contact closed; then BOUNCE_OUT (or GAP if BOUNCE_CYCLES=0).
REQ-019 BOUNCE_OUT lasts BOUNCE_CYCLES enabled cycles, contact = ~counter bit 0; then GAP.
REQ-020 GAP lasts GAP_CYCLES enabled cycles with contact open; then IDLE, with done=1 for that single transition cycle.
REQ-021 col is combinational from row and the registered contact/key state: col = onehot(key_col) when contact closed and row[key_row]=1, else 4'b0000; zero-cycle row-to-col latency.
REQ-022 Row bits other than key_row are ignored; multiple asserted rows still return the key column if key_row is among them.
REQ-023 en low: state, counter and contact are frozen; col still follows row combinationally; done is not asserted.
REQ-024 key_valid during a busy sequence is ignored (key_ready=0); no queuing.
REQ-025 Phase counter width = $clog2(max(HOLD_CYCLES,GAP_CYCLES,BOUNCE_CYCLES)+1); it never wraps within a phase.
REQ-026 HOLD_CYCLES and GAP_CYCLES are >=1; an elaboration-time check fails the build otherwise.

Reset
REQ-027 rst=1 at a clk edge forces state IDLE, counter 0, contact open, captured key 0, done 0; col=0, busy=0.
REQ-028 rst mid-sequence aborts the press immediately: col=0 from the next cycle, with no done pulse.
REQ-029 rst takes priority over en and key_valid.

Structure
REQ-030 The shared keypad package holds the state enum, the 4-bit key code typedef with row/col field helpers, and the row/col width constant (4).
REQ-031 The block has one sub-module, keypad_phase_counter (load, enable, terminal-count flag); everything else is in keypad_matrix_emu.

Verification
REQ-032 Reset: rst=1 for 2 cycles with key_valid=1 -> key_ready=0 during reset, col=0, busy=0.
REQ-033 Defaults, key_code=4'b0110, row walked 0001/0010/0100/1000 each cycle -> col=0100 only when row=0010 and contact closed; the HOLD window is exactly 16 cycles; done pulses 4+16+4+8 cycles after the transfer.
REQ-034 BOUNCE_CYCLES=4, row=4'b0001, key_code=4'b0011 -> col toggles 0000/1000 over 4 cycles, holds 1000 for 16 cycles, then toggles again.
REQ-035 en deasserted for 5 cycles mid-HOLD -> HOLD is extended by exactly 5 cycles; col unchanged during the freeze.
REQ-036 Second key_valid while busy -> ignored; the next transfer occurs only on the first cycle after done, with key_ready=1.
REQ-037 rst asserted in HOLD cycle 3 -> col=0 the next cycle, state IDLE, no done pulse.
